cds_readout_ctrl: RTL and testbench

//  Column-readout sequencer directly downstream of the SAR ADC. Per pixel it runs two

---
 rtl/sensor_readout_pkg.sv | 25 ++
 rtl/cds_sync_fifo.sv | 55 +++++
 rtl/cds_readout_ctrl.sv | 147 ++++++++++++++
 tb/tb_cds_readout_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_readout_pkg.sv
// Shared types and helpers for the column CDS readout sequencer.
// Optional black-level subtraction is enabled with CDS_BLACK_LEVEL_EN.
package sensor_readout_pkg;

    localparam int SAT_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        CHK,
        RST_CONV,
        GAP,
        SIG_CONV,
        PUSH,
        END
    } cds_state_t;

    // Subtract with clamp at zero; callers zero-extend into SAT_W
    function automatic logic [SAT_W-1:0] sat_sub(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b
    );
        return (a >= b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/cds_sync_fifo.sv
// Synchronous FIFO with occupancy count and valid/ready read side.
// DEPTH must be a power of two so the pointers wrap naturally.
module cds_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW  = $clog2(DEPTH);
    localparam int CNW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNW-1:0]   count_q;
    logic             push;
    logic             pop;

    assign rd_valid_o = (count_q != '0);
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign pop        = rd_valid_o & rd_ready_i;
    assign push       = wr_en_i & (count_q != CNW'(DEPTH));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNW'(push) - CNW'(pop);
        end
    end

endmodule

// File: rtl/cds_readout_ctrl.sv
// Column readout sequencer: two ADC conversions per pixel, digital CDS, FIFO out.
// Define CDS_BLACK_LEVEL_EN to add the black_level input and subtraction.
module cds_readout_ctrl
    import sensor_readout_pkg::*;
#(
    parameter int RESOLUTION = 8,
    parameter int NUM_COLS   = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(NUM_COLS)
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef CDS_BLACK_LEVEL_EN
    input  logic [RESOLUTION-1:0] black_level,
`endif
    input  logic                  start_row,
    output logic                  adc_enable,
    input  logic                  adc_done,
    input  logic [RESOLUTION-1:0] adc_data,
    output logic                  sample_sel,
    output logic [CW-1:0]         col_addr,
    output logic [RESOLUTION-1:0] pix_data,
    output logic                  pix_last,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  row_busy,
    output logic                  row_done,
    output logic                  overrun
);

    localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

    cds_state_t            state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RESOLUTION-1:0] rst_code_q, rst_code_d;
    logic [RESOLUTION-1:0] sig_code_q, sig_code_d;
    logic                  overrun_q, overrun_d;
    logic [CNTW-1:0]       fifo_cnt;
    logic                  push;
    logic                  last;
    logic [RESOLUTION-1:0] result;

    assign last = (col_q == CW'(NUM_COLS - 1));

`ifdef CDS_BLACK_LEVEL_EN
    assign result = RESOLUTION'(sat_sub(
        sat_sub(SAT_W'(rst_code_q), SAT_W'(sig_code_q)),
        SAT_W'(black_level)));
`else
    assign result = RESOLUTION'(sat_sub(
        SAT_W'(rst_code_q), SAT_W'(sig_code_q)));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            rst_code_q <= '0;
            sig_code_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            rst_code_q <= rst_code_d;
            sig_code_q <= sig_code_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        rst_code_d = rst_code_q;
        sig_code_d = sig_code_q;
        overrun_d  = overrun_q | (start_row & (state_q != IDLE));
        adc_enable = 1'b0;
        sample_sel = 1'b0;
        row_done   = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_row) begin
                    state_d = CHK;
                    col_d   = '0;
                end
            end
            CHK: begin
                if (fifo_cnt < CNTW'(FIFO_DEPTH)) begin
                    state_d = RST_CONV;
                end
            end
            RST_CONV: begin
                adc_enable = 1'b1;
                if (adc_done) begin
                    rst_code_d = adc_data;
                    state_d    = GAP;
                end
            end
            GAP: begin
                sample_sel = 1'b1;
                state_d    = SIG_CONV;
            end
            SIG_CONV: begin
                adc_enable = 1'b1;
                sample_sel = 1'b1;
                if (adc_done) begin
                    sig_code_d = adc_data;
                    state_d    = PUSH;
                end
            end
            PUSH: begin
                push = 1'b1;
                if (last) begin
                    state_d = END;
                end else begin
                    col_d   = col_q + 1'b1;
                    state_d = CHK;
                end
            end
            END: begin
                row_done = 1'b1;
                col_d    = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign row_busy = (state_q != IDLE);
    assign col_addr = col_q;
    assign overrun  = overrun_q;

    cds_sync_fifo #(
        .WIDTH (RESOLUTION + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_en_i    (push),
        .wr_data_i  ({last, result}),
        .rd_valid_o (pix_valid),
        .rd_ready_i (pix_ready),
        .rd_data_o  ({pix_last, pix_data}),
        .count_o    (fifo_cnt)
    );

endmodule

// File: tb/tb_cds_readout_ctrl.sv
// Directed bench for cds_readout_ctrl with a fixed-latency ADC model.
// Build with CDS_BLACK_LEVEL_EN to also exercise black-level subtraction.
module tb_cds_readout_ctrl;

    localparam int RES  = 8;
    localparam int NC   = 4;
    localparam int FD   = 2;
    localparam int CONV = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           start_row = 1'b0;
    logic           adc_enable;
    logic           adc_done = 1'b0;
    logic [RES-1:0] adc_data = '0;
    logic           sample_sel;
    logic [1:0]     col_addr;
    logic [RES-1:0] pix_data;
    logic           pix_last;
    logic           pix_valid;
    logic           pix_ready = 1'b1;
    logic           row_busy;
    logic           row_done;
    logic           overrun;
`ifdef CDS_BLACK_LEVEL_EN
    logic [RES-1:0] black_level = '0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [RES-1:0] rst_tab [NC];
    logic [RES-1:0] sig_tab [NC];
    int             adc_cnt = 0;

    logic [RES:0]   out_q [$];
    logic           ss_q  [$];
    int             rd_cnt = 0;

    always #5 clk = ~clk;

    cds_readout_ctrl #(
        .RESOLUTION (RES),
        .NUM_COLS   (NC),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef CDS_BLACK_LEVEL_EN
        .black_level(black_level),
`endif
        .start_row  (start_row),
        .adc_enable (adc_enable),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .sample_sel (sample_sel),
        .col_addr   (col_addr),
        .pix_data   (pix_data),
        .pix_last   (pix_last),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .row_busy   (row_busy),
        .row_done   (row_done),
        .overrun    (overrun)
    );

    // ADC: strobes done CONV enabled cycles after enable, then re-arms
    always @(posedge clk) begin
        if (reset || !adc_enable || adc_done) begin
            adc_cnt  <= 0;
            adc_done <= 1'b0;
        end else if (adc_cnt == CONV - 1) begin
            adc_done <= 1'b1;
            adc_data <= sample_sel ? sig_tab[col_addr] : rst_tab[col_addr];
        end else begin
            adc_cnt <= adc_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (pix_valid && pix_ready) out_q.push_back({pix_last, pix_data});
        if (row_done) rd_cnt++;
        if (adc_done && adc_enable) ss_q.push_back(sample_sel);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_tab(input logic [RES-1:0] r0, s0, r1, s1,
                           input logic [RES-1:0] r2, s2, r3, s3);
        rst_tab[0] = r0; sig_tab[0] = s0;
        rst_tab[1] = r1; sig_tab[1] = s1;
        rst_tab[2] = r2; sig_tab[2] = s2;
        rst_tab[3] = r3; sig_tab[3] = s3;
    endtask

    task automatic pulse_start();
        start_row = 1'b1;
        tick(1);
        start_row = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 600; k++) begin
            if (!row_busy) break;
            tick(1);
        end
        if (k == 600) chk({tag, "_timeout"}, 0, 1);
        tick(8);
    endtask

    task automatic chk_row(input string tag, input int base,
                           input logic [RES-1:0] e0, e1, e2, e3);
        logic [RES-1:0] e [NC];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, out_q.size() - base, NC);
        for (int i = 0; i < NC; i++) begin
            if (base + i < out_q.size()) begin
                chk($sformatf("%s_data%0d", tag, i), out_q[base+i][RES-1:0], e[i]);
                chk($sformatf("%s_last%0d", tag, i), out_q[base+i][RES], (i == NC-1));
            end
        end
    endtask

    initial begin
        int ob;
        int sb;
        int rb;
        int k;
        set_tab(200, 50, 200, 50, 200, 50, 200, 50);
        tick(3);
        reset = 1'b0;
        chk("rst_adc_enable", adc_enable, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_row_busy", row_busy, 0);
        chk("rst_col_addr", col_addr, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_row_done", row_done, 0);
        chk("rst_sample_sel", sample_sel, 0);

        // basic row
        ob = out_q.size(); sb = ss_q.size(); rb = rd_cnt;
        pulse_start();
        chk("t1_busy", row_busy, 1);
        wait_idle("t1");
        chk_row("t1", ob, 150, 150, 150, 150);
        chk("t1_row_done", rd_cnt - rb, 1);
        chk("t1_ss_count", ss_q.size() - sb, 2 * NC);
        for (int i = 0; i < 2 * NC; i++)
            if (sb + i < ss_q.size())
                chk($sformatf("t1_ss%0d", i), ss_q[sb+i], i % 2);
        chk("t1_col_back0", col_addr, 0);
        chk("t1_overrun", overrun, 0);

        // clamp and extremes
        set_tab(10, 30, 255, 255, 255, 0, 200, 50);
        ob = out_q.size();
        pulse_start();
        wait_idle("t2");
        chk_row("t2", ob, 0, 0, 255, 150);

        // backpressure
        set_tab(100, 0, 110, 0, 120, 0, 130, 0);
        pix_ready = 1'b0;
        ob = out_q.size();
        pulse_start();
        tick(60);
        chk("t3_stall_enable", adc_enable, 0);
        chk("t3_stall_busy", row_busy, 1);
        chk("t3_stall_col", col_addr, 2);
        chk("t3_stall_valid", pix_valid, 1);
        tick(5);
        chk("t3_stall_hold", adc_enable, 0);
        chk("t3_stall_data", pix_data, 100);
        pix_ready = 1'b1;
        wait_idle("t3");
        chk_row("t3", ob, 100, 110, 120, 130);

        // reset during SIG_CONV of column 2
        set_tab(200, 50, 200, 50, 200, 50, 200, 50);
        pulse_start();
        for (k = 0; k < 400; k++) begin
            if (col_addr == 2 && adc_enable && sample_sel) break;
            tick(1);
        end
        chk("t4_reached_sig2", k < 400, 1);
        reset = 1'b1;
        tick(1);
        chk("t4_adc_enable", adc_enable, 0);
        chk("t4_pix_valid", pix_valid, 0);
        chk("t4_row_busy", row_busy, 0);
        chk("t4_col_addr", col_addr, 0);
        reset = 1'b0;
        tick(2);
        ob = out_q.size();
        pulse_start();
        chk("t4_restart_col", col_addr, 0);
        chk("t4_restart_busy", row_busy, 1);
        wait_idle("t4");
        chk_row("t4", ob, 150, 150, 150, 150);

        // start_row while busy
        ob = out_q.size(); rb = rd_cnt;
        pulse_start();
        tick(5);
        chk("t5_pre_overrun", overrun, 0);
        pulse_start();
        chk("t5_overrun_set", overrun, 1);
        wait_idle("t5");
        chk_row("t5", ob, 150, 150, 150, 150);
        chk("t5_row_done", rd_cnt - rb, 1);
        chk("t5_overrun_sticky", overrun, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t5_overrun_clear", overrun, 0);

`ifdef CDS_BLACK_LEVEL_EN
        black_level = 20;
        set_tab(100, 60, 100, 90, 100, 0, 20, 0);
        ob = out_q.size();
        pulse_start();
        wait_idle("t6");
        chk_row("t6", ob, 20, 0, 80, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
